// File: rtl/d16_pkg.sv
// Shared types and constants for the link-register call/return sequencer.
package d16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALL_WR = 2'd1,
        RET_WR  = 2'd2
    } lr_state_e;

endpackage

// File: rtl/lr_ret_stack.sv
// Circular return-address stack: one write port, asynchronous read of the top
// entry, pointer/occupancy tracking and sticky overflow/underflow flags.
module lr_ret_stack
    import d16_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic [AW:0]       depth,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_flags
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     sp_q, sp_d;
    logic [AW:0]       depth_q, depth_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              ovf_set, udf_set;

    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (push) begin
            // When full the write pointer wraps onto the oldest entry.
            sp_d = sp_q + AW'(1);
            if (depth_q != FULL) depth_d = depth_q + (AW+1)'(1);
            else                 ovf_set = 1'b1;
        end else if (pop) begin
            if (depth_q != '0) begin
                sp_d    = sp_q - AW'(1);
                depth_d = depth_q - (AW+1)'(1);
            end else begin
                udf_set = 1'b1;
            end
        end
        // A new event in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~clr_flags);
        udf_d = udf_set | (udf_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[sp_q] <= push_data;
    end

    assign pop_data  = (depth_q == '0) ? '0 : mem[sp_q - AW'(1)];
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: rtl/lr_call_ctrl.sv
// CALL/RET sequencer for the 16-bit link register: saves/restores LR through
// the return stack and issues the RET jump target.
module lr_call_ctrl
    import d16_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_valid,
    input  logic [WORD_W-1:0] call_addr,
    output logic              call_ready,
    input  logic              ret_valid,
    output logic              ret_ready,
    output logic [WORD_W-1:0] ret_target,
    output logic              ret_target_valid,
    input  logic [WORD_W-1:0] lr_q,
    output logic              lr_wr_en,
    output logic [WORD_W-1:0] lr_d,
    output logic [AW:0]       depth,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_flags
);

    lr_state_e         state_q, state_d;
    logic              lr_wr_en_q, lr_wr_en_d;
    logic [WORD_W-1:0] lr_d_q, lr_d_d;
    logic [WORD_W-1:0] ret_target_q, ret_target_d;
    logic              ret_target_valid_q, ret_target_valid_d;
    logic [WORD_W-1:0] pop_data;
    logic              call_acc, ret_acc;

    // RET has priority, so a simultaneous CALL simply waits for the next IDLE.
    assign ret_ready  = (state_q == IDLE) && !rst;
    assign call_ready = ret_ready && !ret_valid;
    assign ret_acc    = ret_valid && ret_ready;
    assign call_acc   = call_valid && call_ready;

    always_comb begin
        state_d            = state_q;
        lr_wr_en_d         = 1'b0;
        lr_d_d             = lr_d_q;
        ret_target_d       = ret_target_q;
        ret_target_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ret_acc) begin
                    state_d            = RET_WR;
                    lr_wr_en_d         = 1'b1;
                    lr_d_d             = pop_data;
                    ret_target_d       = lr_q;
                    ret_target_valid_d = 1'b1;
                end else if (call_acc) begin
                    state_d    = CALL_WR;
                    lr_wr_en_d = 1'b1;
                    lr_d_d     = call_addr;
                end
            end
            CALL_WR, RET_WR: state_d = IDLE;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            lr_wr_en_q         <= 1'b0;
            lr_d_q             <= '0;
            ret_target_q       <= '0;
            ret_target_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            lr_wr_en_q         <= lr_wr_en_d;
            lr_d_q             <= lr_d_d;
            ret_target_q       <= ret_target_d;
            ret_target_valid_q <= ret_target_valid_d;
        end
    end

    lr_ret_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (call_acc),
        .push_data (lr_q),
        .pop       (ret_acc),
        .pop_data  (pop_data),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_flags (clr_flags)
    );

    assign lr_wr_en         = lr_wr_en_q;
    assign lr_d             = lr_d_q;
    assign ret_target       = ret_target_q;
    assign ret_target_valid = ret_target_valid_q;

endmodule

// File: tb/tb_lr_call_ctrl.sv
// Directed bench for lr_call_ctrl: a queue model of the return stack predicts
// every LR write and RET target; a monitor pops and compares them.
module tb_lr_call_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call_valid = 1'b0;
    logic [15:0] call_addr = '0;
    logic        call_ready;
    logic        ret_valid = 1'b0;
    logic        ret_ready;
    logic [15:0] ret_target;
    logic        ret_target_valid;
    logic [15:0] lr_reg = '0;
    logic        lr_wr_en;
    logic [15:0] lr_d;
    logic [AW:0] depth;
    logic        overflow;
    logic        underflow;
    logic        clr_flags = 1'b0;
    logic        lr_load = 1'b0;
    logic [15:0] lr_load_val = '0;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_lr[$];
    logic [15:0] exp_tgt[$];
    logic [15:0] mstk[$];
    logic [15:0] mlr = '0;
    logic [15:0] last_tgt = '0;
    bit          movf = 0;
    bit          mudf = 0;

    lr_call_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .call_valid       (call_valid),
        .call_addr        (call_addr),
        .call_ready       (call_ready),
        .ret_valid        (ret_valid),
        .ret_ready        (ret_ready),
        .ret_target       (ret_target),
        .ret_target_valid (ret_target_valid),
        .lr_q             (lr_reg),
        .lr_wr_en         (lr_wr_en),
        .lr_d             (lr_d),
        .depth            (depth),
        .overflow         (overflow),
        .underflow        (underflow),
        .clr_flags        (clr_flags)
    );

    always #5 clk = ~clk;

    // The link register itself lives in the bench.
    always @(posedge clk) begin
        if (lr_load)       lr_reg <= lr_load_val;
        else if (lr_wr_en) lr_reg <= lr_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (lr_wr_en !== 1'b0) begin
            if (exp_lr.size() == 0) chk("lr_wr_unexpected", {31'd0, lr_wr_en}, 32'd0);
            else begin
                e = exp_lr.pop_front();
                chk("lr_d", {16'd0, lr_d}, {16'd0, e});
                $display("LR write: lr_d=0x%04h expected=0x%04h", lr_d, e);
            end
        end
        if (ret_target_valid !== 1'b0) begin
            if (exp_tgt.size() == 0) chk("ret_tgt_unexpected", {31'd0, ret_target_valid}, 32'd0);
            else begin
                e = exp_tgt.pop_front();
                chk("ret_target", {16'd0, ret_target}, {16'd0, e});
                $display("RET target: 0x%04h expected=0x%04h", ret_target, e);
            end
        end
    end

    task automatic m_clear();
        mstk.delete();
        movf = 0;
        mudf = 0;
    endtask

    task automatic m_call(input logic [15:0] addr);
        if (mstk.size() == DEPTH) begin
            mstk.delete(0);
            movf = 1;
        end
        mstk.push_back(mlr);
        exp_lr.push_back(addr);
        mlr = addr;
    endtask

    task automatic m_ret(input bit clr);
        logic [15:0] v;
        bit          und;
        und = (mstk.size() == 0);
        exp_tgt.push_back(mlr);
        last_tgt = mlr;
        if (und) v = '0;
        else     v = mstk.pop_back();
        if (clr) begin
            movf = 0;
            mudf = 0;
        end
        if (und) mudf = 1;
        exp_lr.push_back(v);
        mlr = v;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_depth"}, {28'd0, depth}, mstk.size());
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, movf});
        chk({tag, "_udf"}, {31'd0, underflow}, {31'd0, mudf});
    endtask

    task automatic do_reset();
        chk("pending_lr", exp_lr.size(), 0);
        chk("pending_tgt", exp_tgt.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        lr_load = 1'b1;
        lr_load_val = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lr_load = 1'b0;
        m_clear();
        mlr = 16'h0000;
    endtask

    task automatic do_call(input logic [15:0] addr);
        @(negedge clk);
        call_valid = 1'b1;
        call_addr = addr;
        m_call(addr);
        @(posedge clk);
        #1;
        call_valid = 1'b0;
        chk("call_ready_busy", {31'd0, call_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_state("call");
    endtask

    task automatic do_ret(input bit clr);
        @(negedge clk);
        ret_valid = 1'b1;
        clr_flags = clr;
        m_ret(clr);
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        clr_flags = 1'b0;
        @(posedge clk);
        #1;
        check_state("ret");
        chk("ret_target_hold", {16'd0, ret_target}, {16'd0, last_tgt});
    endtask

    initial begin
        // Reset and idle
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("idle");
        chk("idle_lr_wr_en", {31'd0, lr_wr_en}, 32'd0);
        chk("idle_rtv", {31'd0, ret_target_valid}, 32'd0);
        chk("idle_call_ready", {31'd0, call_ready}, 32'd1);
        chk("idle_ret_ready", {31'd0, ret_ready}, 32'd1);

        // Single CALL, then return from it
        do_call(16'h1234);
        do_ret(1'b0);

        // Nested CALLs unwound by two RETs
        do_reset();
        do_call(16'h1234);
        do_call(16'h2000);
        do_ret(1'b0);
        do_ret(1'b0);

        // Overflow: nine CALLs into eight entries, then eight RETs
        do_reset();
        for (int i = 0; i < 9; i++) do_call(16'h0100 + 16'(i));
        for (int i = 0; i < 8; i++) do_ret(1'b0);

        // Underflow from an empty stack with LR=0xBEEF
        @(negedge clk);
        lr_load = 1'b1;
        lr_load_val = 16'hBEEF;
        @(negedge clk);
        lr_load = 1'b0;
        mlr = 16'hBEEF;
        do_ret(1'b0);

        // Plain clear of both flags
        @(negedge clk);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        movf = 0;
        mudf = 0;
        check_state("clr");

        // Clear coinciding with a new underflow: the set wins
        do_ret(1'b1);

        // Simultaneous CALL and RET, then reset during CALL_WR
        do_reset();
        do_call(16'h3000);
        @(negedge clk);
        call_valid = 1'b1;
        ret_valid = 1'b1;
        call_addr = 16'h4000;
        m_ret(1'b0);
        m_call(16'h4000);
        #1;
        chk("both_call_ready", {31'd0, call_ready}, 32'd0);
        chk("both_ret_ready", {31'd0, ret_ready}, 32'd1);
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pending_call_ready", {31'd0, call_ready}, 32'd1);
        @(posedge clk);
        #1;
        call_valid = 1'b0;
        chk("call_wr_ready", {31'd0, call_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        chk("rst_lr_wr_en", {31'd0, lr_wr_en}, 32'd0);
        check_state("rst");
        do_ret(1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("final_pending_lr", exp_lr.size(), 0);
        chk("final_pending_tgt", exp_tgt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
